// File: rtl/icache_pkg.sv
// Shared types and field-width helpers for the direct-mapped instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MISS_REQ = 2'd1,
    REFILL   = 2'd2
  } state_e;

  function automatic int off_w(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

endpackage

// File: rtl/icache_direct_mapped_if.sv
// Fetch-side and refill-side handshakes of the instruction cache.
interface icache_direct_mapped_if #(
  parameter int ADDR_W = 32
);
  logic              cpu_req_valid;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_resp_valid;
  logic              cpu_resp_ready;
  logic [31:0]       cpu_resp_data;
  logic              cpu_resp_err;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [31:0]       mem_resp_data;

  modport slave (
    input  cpu_req_valid, cpu_req_addr, cpu_resp_ready,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_err,
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready, mem_resp_valid, mem_resp_data
  );

  modport master (
    output cpu_req_valid, cpu_req_addr, cpu_resp_ready,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_data, cpu_resp_err,
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready, mem_resp_valid, mem_resp_data
  );
endinterface

// File: rtl/icache_line_store.sv
// Line storage: data and tag arrays plus valid vector with invalidate-all.
module icache_line_store #(
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 16,
  parameter int TAG_W      = 22,
  localparam int IDX_W     = $clog2(NUM_SETS),
  localparam int WRD_W     = $clog2(LINE_WORDS)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [IDX_W-1:0] rd_set_i,
  input  logic [WRD_W-1:0] rd_word_i,
  input  logic [TAG_W-1:0] rd_tag_i,
  output logic [31:0]      rd_data_o,
  output logic             rd_hit_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_set_i,
  input  logic [WRD_W-1:0] wr_word_i,
  input  logic [31:0]      wr_data_i,
  input  logic             commit_i,
  input  logic [TAG_W-1:0] commit_tag_i,
  input  logic             inv_all_i
);
  logic [31:0]         data_q [NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;

  always_ff @(posedge clock) begin
    if (wr_en_i) data_q[wr_set_i][wr_word_i] <= wr_data_i;
    if (commit_i) tag_q[wr_set_i] <= commit_tag_i;
  end

  // Invalidate wins so a flush during refill also drops the new line.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else if (inv_all_i) valid_q <= '0;
    else if (commit_i) valid_q[wr_set_i] <= 1'b1;
  end

  assign rd_data_o = data_q[rd_set_i][rd_word_i];
  assign rd_hit_o  = valid_q[rd_set_i] &&
                     (tag_q[rd_set_i] == rd_tag_i);
endmodule

// File: rtl/icache_direct_mapped.sv
// Blocking direct-mapped I-cache: 1-cycle hits, line refill over a burst handshake.
module icache_direct_mapped
  import icache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 64,
  parameter int LINE_WORDS = 16,
  parameter int CNT_W      = 32
) (
  input  logic                    clock,
  input  logic                    reset_n,
  icache_direct_mapped_if.slave   bus,
  input  logic                    flush,
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);
  localparam int OFF_W = off_w(LINE_WORDS);
  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int WRD_W = OFF_W - 2;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  state_e state_q, state_d;
  logic [ADDR_W-1:2] addr_q, addr_d;
  logic [WRD_W-1:0]  beat_q, beat_d;
  logic [31:0]       word_q, word_d;
  logic              pend_q, pend_d;
  logic              rv_q, rv_d;
  logic [31:0]       rdat_q, rdat_d;
  logic              rerr_q, rerr_d;
  logic [CNT_W-1:0]  hit_q, hit_d, miss_q, miss_d;

  logic        accept, misal, hit, wr_en, commit, inv_all, mreq;
  logic [31:0] rd_data;

  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [IDX_W-1:0] req_set, miss_set;
  logic [WRD_W-1:0] req_word, miss_word;

  assign req_tag   = bus.cpu_req_addr[ADDR_W-1 -: TAG_W];
  assign req_set   = bus.cpu_req_addr[OFF_W +: IDX_W];
  assign req_word  = bus.cpu_req_addr[2 +: WRD_W];
  assign miss_tag  = addr_q[ADDR_W-1 -: TAG_W];
  assign miss_set  = addr_q[OFF_W +: IDX_W];
  assign miss_word = addr_q[2 +: WRD_W];
  assign misal     = |bus.cpu_req_addr[1:0];

  assign bus.cpu_req_ready = reset_n && (state_q == IDLE) && !flush &&
                             (!rv_q || bus.cpu_resp_ready);
  assign accept = bus.cpu_req_valid && bus.cpu_req_ready;

  icache_line_store #(
    .NUM_SETS   (NUM_SETS),
    .LINE_WORDS (LINE_WORDS),
    .TAG_W      (TAG_W)
  ) u_store (
    .clock        (clock),
    .reset_n      (reset_n),
    .rd_set_i     (req_set),
    .rd_word_i    (req_word),
    .rd_tag_i     (req_tag),
    .rd_data_o    (rd_data),
    .rd_hit_o     (hit),
    .wr_en_i      (wr_en),
    .wr_set_i     (miss_set),
    .wr_word_i    (beat_q),
    .wr_data_i    (bus.mem_resp_data),
    .commit_i     (commit),
    .commit_tag_i (miss_tag),
    .inv_all_i    (inv_all)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    beat_d  = beat_q;
    word_d  = word_q;
    pend_d  = pend_q;
    rv_d    = rv_q;
    rdat_d  = rdat_q;
    rerr_d  = rerr_q;
    hit_d   = hit_q;
    miss_d  = miss_q;
    wr_en   = 1'b0;
    commit  = 1'b0;
    inv_all = 1'b0;
    mreq    = 1'b0;
    if (rv_q && bus.cpu_resp_ready) begin
      rv_d   = 1'b0;
      rdat_d = '0;
      rerr_d = 1'b0;
    end
    unique case (state_q)
      IDLE: begin
        inv_all = flush;
        if (accept) begin
          if (misal) begin
            rv_d   = 1'b1;
            rdat_d = '0;
            rerr_d = 1'b1;
          end else if (hit) begin
            rv_d   = 1'b1;
            rdat_d = rd_data;
            rerr_d = 1'b0;
            hit_d  = hit_q + CNT_W'(1);
          end else begin
            addr_d  = bus.cpu_req_addr[ADDR_W-1:2];
            miss_d  = miss_q + CNT_W'(1);
            state_d = MISS_REQ;
          end
        end
      end
      MISS_REQ: begin
        mreq = 1'b1;
        if (flush) pend_d = 1'b1;
        if (bus.mem_req_ready) begin
          state_d = REFILL;
          beat_d  = '0;
        end
      end
      REFILL: begin
        if (flush) pend_d = 1'b1;
        if (bus.mem_resp_valid) begin
          wr_en  = 1'b1;
          beat_d = beat_q + WRD_W'(1);
          if (beat_q == miss_word) word_d = bus.mem_resp_data;
          if (&beat_q) begin
            commit  = 1'b1;
            inv_all = pend_q || flush;
            pend_d  = 1'b0;
            rv_d    = 1'b1;
            rerr_d  = 1'b0;
            rdat_d  = (beat_q == miss_word) ? bus.mem_resp_data
                                            : word_q;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      beat_q  <= '0;
      word_q  <= '0;
      pend_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdat_q  <= '0;
      rerr_q  <= 1'b0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      beat_q  <= beat_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      rv_q    <= rv_d;
      rdat_q  <= rdat_d;
      rerr_q  <= rerr_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  assign bus.mem_req_valid  = mreq;
  assign bus.mem_req_addr   = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
  assign bus.cpu_resp_valid = rv_q;
  assign bus.cpu_resp_data  = rdat_q;
  assign bus.cpu_resp_err   = rerr_q;
  assign hit_count          = hit_q;
  assign miss_count         = miss_q;
endmodule

// File: tb/tb_icache_direct_mapped.sv
// Scoreboard bench for icache_direct_mapped with a line-burst memory model.
module tb_icache_direct_mapped;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] hit_count, miss_count;

  icache_direct_mapped_if #(.ADDR_W(32)) bus ();

  icache_direct_mapped #(
    .ADDR_W     (32),
    .NUM_SETS   (64),
    .LINE_WORDS (16),
    .CNT_W      (32)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bus        (bus),
    .flush      (flush),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clock = ~clock;

  int          checks = 0;
  int          failures = 0;
  logic [32:0] exp_q[$];
  logic [32:0] mon_e;
  int          req_cnt = 0;
  logic [31:0] last_req = '0;
  int          mem_beat = -1;
  bit          mem_busy = 1'b0;
  int          lat;
  int          base;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // Scoreboard monitor: every consumed response pops one expectation.
  always @(negedge clock) begin
    if (reset_n && bus.cpu_resp_valid && bus.cpu_resp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp actual=%h required=none",
                 bus.cpu_resp_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("resp_data", bus.cpu_resp_data, mon_e[31:0]);
        chk("resp_err", {31'd0, bus.cpu_resp_err}, {31'd0, mon_e[32]});
      end
    end
  end

  // Memory: word i at byte 4i holds 0xA000_0000+i.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clock); #1;
      if (bus.mem_req_valid) begin
        mem_busy = 1'b1;
        last_req = bus.mem_req_addr;
        req_cnt++;
        bus.mem_req_ready = 1'b1;
        @(posedge clock); #1;
        bus.mem_req_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
          mem_beat           = i;
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = 32'hA000_0000 + (last_req >> 2) + i;
          @(posedge clock); #1;
        end
        bus.mem_resp_valid = 1'b0;
        mem_beat = -1;
        mem_busy = 1'b0;
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] d,
                       input logic e, input bit wait_resp,
                       output int l);
    bit ok;
    @(posedge clock); #1;
    exp_q.push_back({e, d});
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = a;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clock);
      ok = bus.cpu_req_ready;
      @(posedge clock); #1;
    end
    bus.cpu_req_valid = 1'b0;
    l = 0;
    if (!ok) timeout("accept");
    else if (wait_resp) begin
      l = 1;
      @(negedge clock);
      while (!bus.cpu_resp_valid && l < 100) begin
        @(negedge clock);
        l++;
      end
      if (!bus.cpu_resp_valid) begin
        l = 0;
        timeout("resp");
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_busy) && n < 300) begin
      @(negedge clock);
      n++;
    end
    if (n >= 300) timeout("drain");
  endtask

  task automatic wait_beat(input int b);
    int n;
    n = 0;
    while (mem_beat != b && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) timeout("beat_wait");
  endtask

  initial begin
    bus.cpu_req_valid  = 1'b0;
    bus.cpu_req_addr   = '0;
    bus.cpu_resp_ready = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_resp_valid", {31'd0, bus.cpu_resp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, bus.cpu_req_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("rst_hits", hit_count, 32'd0);
    chk("rst_miss", miss_count, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("idle_ready", {31'd0, bus.cpu_req_ready}, 32'd1);

    // Cold miss on line 0
    fetch(32'h0000_0008, 32'hA000_0002, 1'b0, 1'b1, lat);
    drain();
    chk("t1_reqs", req_cnt, 32'd1);
    chk("t1_req_addr", last_req, 32'h0);
    chk("t1_miss", miss_count, 32'd1);
    chk("t1_hits", hit_count, 32'd0);

    // Hit with response held under backpressure
    bus.cpu_resp_ready = 1'b0;
    fetch(32'h0000_003C, 32'hA000_000F, 1'b0, 1'b1, lat);
    chk("t2_latency", lat, 32'd1);
    for (int k = 0; k < 3; k++) begin
      chk("t2_hold_valid", {31'd0, bus.cpu_resp_valid}, 32'd1);
      chk("t2_hold_data", bus.cpu_resp_data, 32'hA000_000F);
      chk("t2_hold_ready", {31'd0, bus.cpu_req_ready}, 32'd0);
      @(negedge clock);
    end
    @(posedge clock); #1;
    bus.cpu_resp_ready = 1'b1;
    drain();
    chk("t2_reqs", req_cnt, 32'd1);
    chk("t2_hits", hit_count, 32'd1);

    // Conflict misses in set 0
    fetch(32'h0000_1000, 32'hA000_0400, 1'b0, 1'b1, lat);
    drain();
    chk("t3_req_addr", last_req, 32'h0000_1000);
    fetch(32'h0000_0000, 32'hA000_0000, 1'b0, 1'b1, lat);
    drain();
    chk("t3_reqs", req_cnt, 32'd3);
    chk("t3_miss", miss_count, 32'd3);

    // Misaligned fetch
    fetch(32'h0000_0006, 32'h0, 1'b1, 1'b1, lat);
    chk("t4_latency", lat, 32'd1);
    drain();
    chk("t4_reqs", req_cnt, 32'd3);
    chk("t4_hits", hit_count, 32'd1);
    chk("t4_miss", miss_count, 32'd3);

    // Flush during refill: response still delivered, lines dropped
    fetch(32'h0000_0040, 32'hA000_0010, 1'b0, 1'b0, lat);
    wait_beat(7);
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    drain();
    chk("t5_miss", miss_count, 32'd4);
    fetch(32'h0000_0040, 32'hA000_0010, 1'b0, 1'b1, lat);
    drain();
    chk("t5_refetch_reqs", req_cnt, 32'd5);
    chk("t5_refetch_miss", miss_count, 32'd5);
    fetch(32'h0000_0008, 32'hA000_0002, 1'b0, 1'b1, lat);
    drain();
    chk("t5_line0_miss", miss_count, 32'd6);
    chk("t5_hits", hit_count, 32'd1);

    // Reset in the middle of a refill
    base = req_cnt;
    fetch(32'h0000_0080, 32'hA000_0020, 1'b0, 1'b0, lat);
    wait_beat(5);
    reset_n = 1'b0;
    #1;
    exp_q.delete();
    chk("t6_resp_valid", {31'd0, bus.cpu_resp_valid}, 32'd0);
    chk("t6_req_ready", {31'd0, bus.cpu_req_ready}, 32'd0);
    chk("t6_mem_req", {31'd0, bus.mem_req_valid}, 32'd0);
    chk("t6_hits", hit_count, 32'd0);
    chk("t6_miss", miss_count, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    drain();
    chk("t6_no_rereq", req_cnt, base + 1);
    fetch(32'h0000_0000, 32'hA000_0000, 1'b0, 1'b1, lat);
    drain();
    chk("t6_miss_after", miss_count, 32'd1);
    chk("t6_reqs_after", req_cnt, base + 2);
    chk("t6_req_addr", last_req, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
